// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads imem at fetch_pc into a FIFO_DEPTH entry buffer drained by decode (valid/ready).
// One cycle fetch-to-output latency; a full buffer stalls fetch with fetch_pc held, or pushes and pops in the same cycle when decode is ready.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 64,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] HALT_WORD  = XLEN'(32'h00000033),
  parameter logic [XLEN-1:0] NOP_WORD   = XLEN'(32'h00000013)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          if_ready,
  output logic                          if_valid,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               instruction,
  output logic                          fetch_fault,
  output logic                          halted
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

  logic [XLEN-1:0] imem [IMEM_DEPTH];
  entry_t          fifo_q [FIFO_DEPTH];
  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            halted_q;
  entry_t          fetch_ent, head;
  logic            in_range, push, pop, hit_halt;

  // Addresses beyond the memory still advance the PC but return a tagged NOP.
  always_comb begin
    in_range        = (fetch_pc[XLEN-1:AW+2] == '0);
    fetch_ent.pc    = fetch_pc;
    fetch_ent.instr = in_range ? imem[fetch_pc[AW+1:2]] : NOP_WORD;
    fetch_ent.fault = !in_range;
  end

  assign head     = fifo_q[rd_ptr];
  assign if_valid = (count != '0);
  assign pop      = if_valid && if_ready;
  assign push     = !reset && !redirect_valid && !halted_q &&
                    ((count < CW'(FIFO_DEPTH)) || pop);
  assign hit_halt = (fetch_ent.instr == HALT_WORD);

  assign pc          = if_valid ? head.pc    : '0;
  assign instruction = if_valid ? head.instr : NOP_WORD;
  assign fetch_fault = if_valid ? head.fault : 1'b0;
  assign halted      = halted_q;

  always_ff @(posedge clk) begin
    if (imem_we && !reset)
      imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= fetch_ent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (hit_halt)
          halted_q <= 1'b1;
        else
          fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 64;
  localparam int          FD    = 2;
  localparam logic [31:0] HALT  = 32'h00000033;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1, imem_we = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0, redirect_pc = '0;
  logic        if_valid, fetch_fault, halted;
  logic [31:0] pc, instruction;
  logic        hi_valid, hi_fault, hi_halted;
  logic [31:0] hi_pc, hi_instr;

  int n_tests = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD), .RESET_PC(32'd0),
                     .HALT_WORD(HALT), .NOP_WORD(NOP)) u_dut (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_ready(if_ready),
    .if_valid(if_valid), .pc(pc), .instruction(instruction), .fetch_fault(fetch_fault), .halted(halted));

  instr_fetch_unit #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD), .RESET_PC(32'((DEPTH-1)*4)),
                     .HALT_WORD(HALT), .NOP_WORD(NOP)) u_hi (
    .clk(clk), .reset(reset), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_ready(if_ready),
    .if_valid(hi_valid), .pc(hi_pc), .instruction(hi_instr), .fetch_fault(hi_fault), .halted(hi_halted));

  logic [66:0] act;
  assign act = {if_valid, pc, instruction, fetch_fault, halted};

  // Reference model: a queue of fetched entries plus the fetch PC and halt flag.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc = '0;
  logic        m_halted = 1'b0;

  function automatic logic [66:0] m_expect();
    if (m_q.size() == 0) return {1'b0, 32'd0, NOP, 1'b0, m_halted};
    return {1'b1, m_q[0].pc, m_q[0].instr, m_q[0].fault, m_halted};
  endfunction

  task automatic m_step();
    bit   do_pop, do_push;
    ent_t e;
    do_pop = (m_q.size() != 0) && if_ready;
    if (reset) begin
      m_q.delete(); m_pc = 32'd0; m_halted = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete(); m_pc = redirect_pc & ~32'd3; m_halted = 1'b0;
    end else begin
      do_push = !m_halted && (m_q.size() < FD || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.pc = m_pc;
        if ((m_pc >> 2) >= DEPTH) begin e.instr = NOP; e.fault = 1'b1; end
        else begin e.instr = m_mem[m_pc >> 2]; e.fault = 1'b0; end
        m_q.push_back(e);
        if (e.instr == HALT) m_halted = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
    if (!reset && imem_we) m_mem[imem_waddr] = imem_wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    n_tests++;
    if (act !== {1'b0, 32'd0, NOP, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_values act=%h exp=%h", act, {1'b0, 32'd0, NOP, 1'b0, 1'b0});
    end
  endtask

  task automatic test_load();
    logic [31:0] w;
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      if (w == HALT) w = w ^ 32'h1;
      case (i)
        0: w = 32'h002081b3;
        1: w = 32'h00418233;
        2: w = 32'h006282b3;
        3: w = 32'h00838333;
        4: w = HALT;
        default: ;
      endcase
      imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = w;
      tick();
    end
    imem_we = 1'b0; redirect_valid = 1'b0; reset = 1'b1;
    tick();
    n_tests++;
    if (act !== m_expect()) begin n_fail++; $display("FAIL load act=%h exp=%h", act, m_expect()); end
  endtask

  task automatic test_halt_stream();
    logic [31:0] got[$];
    reset = 1'b1; if_ready = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (if_valid && if_ready) got.push_back(pc);
      tick();
      n_tests++;
      if (act !== m_expect()) begin n_fail++; $display("FAIL halt_stream cyc=%0d act=%h exp=%h", cyc, act, m_expect()); end
      if (i == 4) begin
        n_tests++;
        if ({halted, pc} !== {1'b1, 32'd16}) begin
          n_fail++; $display("FAIL halt_visible got halted=%b pc=%h want halted=1 pc=10", halted, pc);
        end
      end
    end
    n_tests++;
    if (got.size() != 5) begin n_fail++; $display("FAIL halt_count got %0d pops want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_tests++;
      if (got[i] !== 32'(4*i)) begin n_fail++; $display("FAIL halt_seq[%0d] got %h want %h", i, got[i], 32'(4*i)); end
    end
    n_tests++;
    if ({if_valid, halted} !== 2'b01) begin n_fail++; $display("FAIL halt_drain got valid=%b halted=%b want 0/1", if_valid, halted); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    reset = 1'b1; if_ready = 1'b0; tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (act !== m_expect()) begin n_fail++; $display("FAIL bp_hold cyc=%0d act=%h exp=%h", cyc, act, m_expect()); end
    end
    n_tests++;
    if ({if_valid, pc} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL bp_head got valid=%b pc=%h want 1/0", if_valid, pc); end
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (if_valid) got.push_back(pc);
      tick();
      n_tests++;
      if (act !== m_expect()) begin n_fail++; $display("FAIL bp_release cyc=%0d act=%h exp=%h", cyc, act, m_expect()); end
    end
    n_tests++;
    if (got.size() != 3 || got[0] !== 32'd0 || got[1] !== 32'd4 || got[2] !== 32'd8) begin
      n_fail++; $display("FAIL bp_order got %p want 0,4,8", got);
    end
  endtask

  task automatic test_redirect();
    reset = 1'b1; if_ready = 1'b0; tick(); reset = 1'b0;
    tick(); if_ready = 1'b1; tick(); if_ready = 1'b0; tick();
    n_tests++;
    if ({if_valid, pc} !== {1'b1, 32'd4}) begin n_fail++; $display("FAIL redir_pre got valid=%b pc=%h want 1/4", if_valid, pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h20; if_ready = 1'b1; tick();
    redirect_valid = 1'b0; if_ready = 1'b0;
    n_tests++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble got valid=%b want 0", if_valid); end
    tick();
    n_tests++;
    if ({if_valid, pc} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL redir_target got valid=%b pc=%h want 1/20", if_valid, pc); end
    if_ready = 1'b1; tick();
    n_tests++;
    if ({if_valid, pc} !== {1'b1, 32'h24}) begin n_fail++; $display("FAIL redir_next got valid=%b pc=%h want 1/24", if_valid, pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h23; if_ready = 1'b0; tick(); redirect_valid = 1'b0; tick();
    n_tests++;
    if ({if_valid, pc} !== {1'b1, 32'h20}) begin n_fail++; $display("FAIL redir_align got valid=%b pc=%h want 1/20", if_valid, pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h10; if_ready = 1'b1; tick(); redirect_valid = 1'b0; tick();
    n_tests++;
    if ({halted, pc} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL redir_halt got halted=%b pc=%h want 1/10", halted, pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h8; tick(); redirect_valid = 1'b0;
    n_tests++;
    if ({halted, if_valid} !== 2'b00) begin n_fail++; $display("FAIL redir_unhalt got halted=%b valid=%b want 0/0", halted, if_valid); end
    tick();
    n_tests++;
    if (act !== m_expect() || pc !== 32'h8) begin n_fail++; $display("FAIL redir_resume act=%h exp=%h", act, m_expect()); end
  endtask

  task automatic test_boundary();
    reset = 1'b1; if_ready = 1'b1; tick(); reset = 1'b0;
    tick();
    n_tests++;
    if ({hi_valid, hi_pc, hi_instr, hi_fault} !== {1'b1, 32'd252, m_mem[63], 1'b0}) begin
      n_fail++; $display("FAIL bound_last got %b %h %h %b want 1 fc %h 0", hi_valid, hi_pc, hi_instr, hi_fault, m_mem[63]);
    end
    tick();
    n_tests++;
    if ({hi_valid, hi_pc, hi_instr, hi_fault} !== {1'b1, 32'd256, NOP, 1'b1}) begin
      n_fail++; $display("FAIL bound_over got %b %h %h %b want 1 100 13 1", hi_valid, hi_pc, hi_instr, hi_fault);
    end
    tick();
    n_tests++;
    if ({hi_valid, hi_pc, hi_instr, hi_fault, hi_halted} !== {1'b1, 32'd260, NOP, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bound_cont got %b %h %h %b %b want 1 104 13 1 0", hi_valid, hi_pc, hi_instr, hi_fault, hi_halted);
    end
  endtask

  task automatic test_rbw();
    logic [31:0] old_w, new_w;
    old_w = m_mem[0]; new_w = 32'h00a00093;
    reset = 1'b1; if_ready = 1'b0; tick(); reset = 1'b0;
    imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = new_w; tick(); imem_we = 1'b0;
    n_tests++;
    if (instruction !== old_w) begin n_fail++; $display("FAIL rbw_old got %h want %h", instruction, old_w); end
    redirect_valid = 1'b1; redirect_pc = 32'h0; tick(); redirect_valid = 1'b0; tick();
    n_tests++;
    if (instruction !== new_w) begin n_fail++; $display("FAIL rbw_new got %h want %h", instruction, new_w); end
  endtask

  task automatic test_random();
    reset = 1'b1; tick();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(99) == 0);
      redirect_valid = ($urandom_range(99) < 6);
      redirect_pc    = 32'($urandom_range(300));
      if_ready       = ($urandom_range(99) < 65);
      imem_we        = ($urandom_range(99) < 20);
      imem_waddr     = 6'($urandom_range(63));
      imem_wdata     = ($urandom_range(9) == 0) ? HALT : $urandom();
      tick();
      n_tests++;
      if (act !== m_expect()) begin n_fail++; $display("FAIL random cyc=%0d act=%h exp=%h", cyc, act, m_expect()); end
    end
    reset = 1'b0; redirect_valid = 1'b0; imem_we = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [31:0] saved;
    reset = 1'b1; if_ready = 1'b1; tick(); reset = 1'b0;
    tick(); tick(); tick();
    saved = m_mem[0];
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = ~saved;
    tick();
    n_tests++;
    if (act !== {1'b0, 32'd0, NOP, 1'b0, 1'b0}) begin n_fail++; $display("FAIL mid_reset act=%h exp=%h", act, {1'b0, 32'd0, NOP, 1'b0, 1'b0}); end
    reset = 1'b0; redirect_valid = 1'b0; imem_we = 1'b0;
    tick();
    n_tests++;
    if ({if_valid, pc, instruction} !== {1'b1, 32'd0, saved}) begin
      n_fail++; $display("FAIL mid_reset_after got %b %h %h want 1 0 %h", if_valid, pc, instruction, saved);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_halt_stream();
    test_backpressure();
    test_redirect();
    test_boundary();
    test_rbw();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
